fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Applies branch/jump redirects and stalls from downstream.
- Drives the IF/ID pipeline register, whose opcode/funct slices feed control_unit directly in ID.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/if_id_reg.sv | 46 ++++
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, reset vector, fetch FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  // Field extraction used by the ID-stage decoder.
  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] instr);
    return instr[5:0];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register holding valid, instruction word and fetch address + 4.
// Latency: one cycle from load_i to outputs.
// Backpressure: stall_i freezes all fields; flush_i clears valid and overrides stall.
module if_id_reg #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [ADDR_W-1:0] pc_plus4_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_plus4_o
);

  logic              valid_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] pc_plus4_q;

  // Flush beats load, load beats consume; consuming only drops valid so the
  // stale word stays visible for debug.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_plus4_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_plus4_q <= pc_plus4_i;
    end else if (!stall_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: owns the PC, one outstanding imem request, feeds IF/ID.
// Latency: request in cycle N, 1-cycle memory -> IF/ID valid in N+2; no prefetch.
// Backpressure: stalled IF/ID parks the returned word in a hold buffer and stops requesting.
module fetch_stage import mips_pkg::*; #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall_id,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc_plus4,
  output logic [5:0]        if_id_opcode,
  output logic [5:0]        if_id_funct
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic              load;
  logic [DATA_W-1:0] load_instr;
  logic              can_accept;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target_pc;

  // Low address bits are never meaningful for word fetches.
  assign target_pc  = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pc_plus4   = pc_q + ADDR_W'(4);
  assign can_accept = !if_id_valid || !stall_id;

  assign imem_req  = (state_q == S_REQ) && !rst;
  assign imem_addr = {pc_q[ADDR_W-1:2], 2'b00};

  // Fetch FSM: a response is only sampled in S_WAIT, so anything arriving
  // after a reset or a drop is ignored; drop marks an in-flight wrong-path word.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    hold_d     = hold_q;
    load       = 1'b0;
    load_instr = imem_rdata;
    case (state_q)
      S_REQ: begin
        if (redirect) pc_d = target_pc;
        if (imem_ready) begin
          state_d = S_WAIT;
          drop_d  = redirect;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
            if (redirect) pc_d = target_pc;
          end else if (can_accept) begin
            load    = 1'b1;
            pc_d    = pc_plus4;
            state_d = S_REQ;
          end else begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          pc_d   = target_pc;
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = target_pc;
          state_d = S_REQ;
        end else if (can_accept) begin
          load       = 1'b1;
          load_instr = hold_q;
          pc_d       = pc_plus4;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Fetch state, PC, drop flag and hold buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= {RESET_PC[ADDR_W-1:2], 2'b00};
      drop_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      hold_q  <= hold_d;
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .stall_i    (stall_id),
    .flush_i    (redirect),
    .instr_i    (load_instr),
    .pc_plus4_i (pc_plus4),
    .valid_o    (if_id_valid),
    .instr_o    (if_id_instr),
    .pc_plus4_o (if_id_pc_plus4)
  );

  assign if_id_opcode = opcode_of(if_id_instr);
  assign if_id_funct  = funct_of(if_id_instr);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences,
// then randomized traffic against a program-order reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall_id = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic [5:0]  if_id_opcode;
  logic [5:0]  if_id_funct;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .stall_id       (stall_id),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_opcode   (if_id_opcode),
    .if_id_funct    (if_id_funct)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2002_0005;
    return (a * 32'h9E37_79B1) + 32'h0123_4567;
  endfunction

  // One clock: drive inputs at the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rd,
                     input logic st, input logic rdr, input logic [31:0] rp);
    @(negedge clk);
    imem_ready  = rdy;
    imem_rvalid = rv;
    imem_rdata  = rd;
    stall_id    = st;
    redirect    = rdr;
    redirect_pc = rp;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic [31:0] rp;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic        chk_dat;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t tbl[20];

  // Random-phase memory and reference state.
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  logic [31:0] exp_pc;
  int          deliveries;

  initial begin
    logic [31:0] ei;
    logic        pv, ps, pr, hs;
    logic [31:0] pinstr, ppc4, hs_addr, rp;
    logic        rv;

    //         rdy rv  rdata          st  rd  rp           req addr          vld dat instr          pc4
    tbl[0]  = '{1, 0, 32'h0,         0, 0, 32'h0,       0, 32'h0000_0000, 0, 1, 32'h0,         32'h0};
    tbl[1]  = '{1, 1, 32'h2002_0005, 0, 0, 32'h0,       1, 32'h0000_0004, 1, 1, 32'h2002_0005, 32'h4};
    tbl[2]  = '{1, 0, 32'h0,         0, 0, 32'h0,       0, 32'h0000_0004, 0, 1, 32'h2002_0005, 32'h4};
    tbl[3]  = '{1, 1, 32'h8C43_0004, 0, 0, 32'h0,       1, 32'h0000_0008, 1, 1, 32'h8C43_0004, 32'h8};
    tbl[4]  = '{1, 0, 32'h0,         1, 0, 32'h0,       0, 32'h0000_0008, 1, 1, 32'h8C43_0004, 32'h8};
    tbl[5]  = '{1, 1, 32'h0043_2020, 1, 0, 32'h0,       0, 32'h0000_0008, 1, 1, 32'h8C43_0004, 32'h8};
    tbl[6]  = '{1, 0, 32'h0,         1, 0, 32'h0,       0, 32'h0000_0008, 1, 1, 32'h8C43_0004, 32'h8};
    tbl[7]  = '{1, 0, 32'h0,         0, 0, 32'h0,       1, 32'h0000_000C, 1, 1, 32'h0043_2020, 32'hC};
    tbl[8]  = '{1, 0, 32'h0,         0, 0, 32'h0,       0, 32'h0000_000C, 0, 1, 32'h0043_2020, 32'hC};
    tbl[9]  = '{1, 1, 32'hAC43_0008, 0, 0, 32'h0,       1, 32'h0000_0010, 1, 1, 32'hAC43_0008, 32'h10};
    tbl[10] = '{1, 0, 32'h0,         0, 0, 32'h0,       0, 32'h0000_0010, 0, 1, 32'hAC43_0008, 32'h10};
    tbl[11] = '{0, 0, 32'h0,         0, 1, 32'h40,      0, 32'h0000_0040, 0, 1, 32'hAC43_0008, 32'h10};
    tbl[12] = '{0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,       1, 32'h0000_0040, 0, 1, 32'hAC43_0008, 32'h10};
    tbl[13] = '{1, 0, 32'h0,         0, 0, 32'h0,       0, 32'h0000_0040, 0, 1, 32'hAC43_0008, 32'h10};
    tbl[14] = '{0, 1, 32'h1000_FFFF, 0, 0, 32'h0,       1, 32'h0000_0044, 1, 1, 32'h1000_FFFF, 32'h44};
    tbl[15] = '{1, 0, 32'h0,         1, 0, 32'h0,       0, 32'h0000_0044, 1, 1, 32'h1000_FFFF, 32'h44};
    tbl[16] = '{0, 1, 32'h0800_0010, 1, 0, 32'h0,       0, 32'h0000_0044, 1, 1, 32'h1000_FFFF, 32'h44};
    tbl[17] = '{0, 0, 32'h0,         1, 1, 32'h103,     1, 32'h0000_0100, 0, 0, 32'h0,         32'h0};
    tbl[18] = '{1, 0, 32'h0,         0, 0, 32'h0,       0, 32'h0000_0100, 0, 0, 32'h0,         32'h0};
    tbl[19] = '{0, 1, 32'h0000_0008, 0, 0, 32'h0,       1, 32'h0000_0104, 1, 1, 32'h0000_0008, 32'h104};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", if_id_valid, 1'b0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc_plus4, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_req", imem_req, 1'b1);

    // Directed vector table.
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].rdy, tbl[i].rv, tbl[i].rdata, tbl[i].stall, tbl[i].redir, tbl[i].rp);
      chk($sformatf("v%0d_req", i), imem_req, tbl[i].e_req);
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_vld", i), if_id_valid, tbl[i].e_vld);
      if (tbl[i].chk_dat) begin
        ei = tbl[i].e_instr;
        chk($sformatf("v%0d_instr", i), if_id_instr, ei);
        chk($sformatf("v%0d_pc4", i), if_id_pc_plus4, tbl[i].e_pc4);
        chk($sformatf("v%0d_opc", i), {26'h0, if_id_opcode}, {26'h0, ei[31:26]});
        chk($sformatf("v%0d_fn", i), {26'h0, if_id_funct}, {26'h0, ei[5:0]});
      end
    end

    // PC wrap: redirect to the last word, fetch it, pc+4 must wrap to 0.
    cyc(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_req", imem_req, 1'b1);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    cyc(0, 1, 32'h0000_000C, 0, 0, 32'h0);
    chk("wrap_vld", if_id_valid, 1'b1);
    chk("wrap_pc4", if_id_pc_plus4, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Redirect in the same cycle the request is accepted: response must be dropped.
    cyc(1, 0, 32'h0, 0, 1, 32'h80);
    chk("acc_redir_vld", if_id_valid, 1'b0);
    cyc(0, 1, 32'hBAD0_0001, 0, 0, 32'h0);
    chk("acc_redir_drop_vld", if_id_valid, 1'b0);
    chk("acc_redir_addr", imem_addr, 32'h80);
    chk("acc_redir_req", imem_req, 1'b1);

    // Reset while waiting on a response, then a stale response after release.
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    imem_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_req", imem_req, 1'b0);
    chk("midrst_vld", if_id_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_req_after", imem_req, 1'b1);
    cyc(0, 1, 32'hBAD0_0002, 0, 0, 32'h0);
    chk("stale_vld", if_id_valid, 1'b0);
    chk("stale_req", imem_req, 1'b1);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    cyc(0, 1, 32'h2002_0005, 0, 0, 32'h0);
    chk("midrst_first_vld", if_id_valid, 1'b1);
    chk("midrst_first_instr", if_id_instr, 32'h2002_0005);
    chk("midrst_first_pc4", if_id_pc_plus4, 32'h4);

    // Randomized traffic: the model tracks only the next program-order address.
    @(negedge clk);
    imem_ready = 1'b0; imem_rvalid = 1'b0; stall_id = 1'b0; redirect = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pend = 1'b0; pend_addr = '0; pend_cnt = 0;
    exp_pc = 32'h0;
    deliveries = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rv = pend && (pend_cnt == 0);
      imem_rvalid = rv;
      imem_rdata  = rv ? mem_word(pend_addr) : $urandom;
      imem_ready  = ($urandom_range(0, 9) < 7);
      stall_id    = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      rp = $urandom;
      if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hF);
      redirect_pc = rp;
      #1;
      if (imem_req) begin
        chk("rnd_req_addr", imem_addr, exp_pc);
        chk("rnd_single_outstanding", pend, 1'b0);
      end
      pv = if_id_valid; ps = stall_id; pr = redirect;
      pinstr = if_id_instr; ppc4 = if_id_pc_plus4;
      hs = imem_req && imem_ready; hs_addr = imem_addr;
      @(posedge clk);
      #1;
      if (rv) pend = 1'b0;
      else if (pend) pend_cnt--;
      if (hs) begin
        pend = 1'b1;
        pend_addr = hs_addr;
        pend_cnt = $urandom_range(0, 2);
      end
      if (pr) begin
        chk("rnd_flush_vld", if_id_valid, 1'b0);
        exp_pc = rp & 32'hFFFF_FFFC;
      end else if (pv && ps) begin
        chk("rnd_hold_vld", if_id_valid, 1'b1);
        chk("rnd_hold_instr", if_id_instr, pinstr);
        chk("rnd_hold_pc4", if_id_pc_plus4, ppc4);
      end else if (if_id_valid) begin
        ei = mem_word(exp_pc);
        chk("rnd_instr", if_id_instr, ei);
        chk("rnd_pc4", if_id_pc_plus4, exp_pc + 32'h4);
        chk("rnd_opcode", {26'h0, if_id_opcode}, {26'h0, ei[31:26]});
        exp_pc = exp_pc + 32'h4;
        deliveries++;
      end
    end
    chk("rnd_progress", (deliveries >= 100) ? 32'h1 : 32'h0, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
